mp64_ext_sram_ctrl: RTL and testbench
=====================================

MP64_EXT_SRAM_CTRL -- requirements
Module: mp64_ext_sram_ctrl

Interface
REQ-001 SHALL have parameter SRAM_AW, default 20, halfword-address width of the external SRAM.
REQ-002 SHALL have parameter WAIT_CYC, default 2, access-strobe cycles per beat; legal range is 1..15.
REQ-003 SHALL use one clock; reset is synchronous and active-low; the ports are named clk and rst_n.
REQ-004 clk  input  1  system clock, all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 ext_req  input  1  request valid; held high by the initiator until ext_ack.
REQ-007 ext_addr  input  64  byte address.
REQ-008 ext_wdata  input  64  write data, value right-justified.
REQ-009 ext_wen  input  1  1 = write, 0 = read.
REQ-010 ext_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-011 ext_rdata  output  64  read data, zero-extended, right-justified.
REQ-012 ext_ack  output  1  one-cycle completion pulse.
REQ-013 sram_addr  output  SRAM_AW  halfword address.
REQ-014 sram_dq_o / sram_dq_i / sram_dq_oe  output / input / output  16 / 16 / 1  data bus out, data bus in, and output enable.
REQ-015 sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes; ub = odd byte, lb = even byte.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS, ACK, RELEASE.
REQ-017 IDLE: on ext_req=1, latch addr/wdata/wen/size, clear ext_rdata to 0, set beat=0, go to SETUP.
REQ-018 Beat count by size: byte 1, half 1, word 2, dword 4.
REQ-019 Address alignment: the address is aligned down to the access size (low bits ignored); start halfword = aligned ext_addr[SRAM_AW:1]; ext_addr bits above SRAM_AW are ignored (wrap).
REQ-020 Beat n address: start + n; each beat carries a 16-bit little-endian chunk, and beat n maps to data bits [16n+15:16n].
REQ-021 Byte lanes: byte accesses drive lb_n low if ext_addr[0]=0 and ub_n low otherwise; all other sizes drive both lanes low.
REQ-022 Byte write: wdata[7:0] is driven on both halves of sram_dq_o.
REQ-023 Byte read: the selected lane is returned in rdata[7:0].
REQ-024 SETUP (1 cycle): sram_addr valid, ce_n=0, we_n=1, oe_n=1; sram_dq_oe=1 if write.
REQ-025 ACCESS (WAIT_CYC cycles): ce_n=0; we_n=0 for writes, oe_n=0 for reads.
REQ-026 Read capture: sram_dq_i is captured into the beat's rdata slice on the last ACCESS cycle.
REQ-027 Wait counter: a wait counter counts ACCESS cycles; on the last one, go to SETUP if more beats remain, else go to ACK.
REQ-028 ACK (1 cycle): ext_ack=1, all strobes inactive, ext_rdata valid; then go to RELEASE.
REQ-029 RELEASE: stay until ext_req is sampled low, then go to IDLE; a request held across the ack is never serviced twice.
REQ-030 Latency: ext_ack asserts beats*(1+WAIT_CYC)+1 cycles after the accepting edge; WAIT_CYC=2 gives byte 4 cycles and dword 13 cycles.
REQ-031 ext_rdata is held after ACK until the next accept; after a write ext_rdata reads 0.
REQ-032 Bus turnaround: sram_dq_oe=0 in every non-write cycle, and always in IDLE, ACK and RELEASE.
REQ-033 Input stability: ext_* inputs changing after accept have no effect on the transaction in flight.

Reset
REQ-034 rst_n=0 forces IDLE on the next edge: ext_ack=0, ext_rdata=0, sram_addr=0, sram_dq_o=0, dq_oe=0, all *_n strobes=1.
REQ-035 Reset asserted mid-transaction aborts the transaction: no ack is issued and no further strobes are driven.

Structure
REQ-036 Package mp64_ext_pkg SHALL hold the size codes SZ_BYTE..SZ_DWORD, the FSM state encoding, and the beats-per-size function.
REQ-037 The block SHALL be a single module with no sub-modules; a behavioural 16-bit SRAM model is bench-only.

Verification
REQ-038 Dword write 0x1122_3344_5566_7788 @0x100, then dword read @0x100 -> SRAM halfwords 0x80..0x83 = 7788, 5566, 3344, 1122; read returns the same value; ack at cycle 13.
REQ-039 Byte write 0xAB @0x203, then dword read @0x200 -> only ub_n low on halfword 0x101, byte 0x203 = 0xAB, neighbour bytes unchanged.
REQ-040 Half read @0x305 -> aligned to 0x304; one beat; rdata = 0x0000_0000_0000_xxxx, where xxxx is the halfword at 0x182, upper bits 0.
REQ-041 Hold ext_req high 3 cycles past ack -> exactly one ack and one SRAM transaction; a new request is accepted only after req is low.
REQ-042 Assert rst_n=0 during beat 2 of a dword write -> next edge all strobes high, no ack; a subsequent read completes normally.
REQ-043 Run with WAIT_CYC=1 -> word read acks at cycle 5; we_n/oe_n pulses are exactly 1 cycle wide.

Source files
------------

// File: rtl/mp64_ext_pkg.sv
// Shared definitions for the 64-bit to 16-bit external SRAM bridge:
// access size codes, controller state encoding and beats-per-size helper.
package mp64_ext_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Number of 16-bit SRAM beats needed for one access of a given size.
    function automatic logic [2:0] beats_of(input logic [1:0] size);
        logic [2:0] n;
        n = 3'd1;
        unique case (size_e'(size))
            SZ_BYTE:  n = 3'd1;
            SZ_HALF:  n = 3'd1;
            SZ_WORD:  n = 3'd2;
            SZ_DWORD: n = 3'd4;
            default:  n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mp64_ext_sram_ctrl.sv
// Bridges a 64-bit req/ack port onto an asynchronous 16-bit SRAM.
// Ports: ext_* request side (req/addr/wdata/wen/size in, rdata/ack out);
// sram_* side: halfword addr, dq out/in/oe, active-low ce/we/oe/ub/lb.
module mp64_ext_sram_ctrl
    import mp64_ext_pkg::*;
#(
    parameter int SRAM_AW  = 20,
    parameter int WAIT_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ext_req,
    input  logic [63:0]        ext_addr,
    input  logic [63:0]        ext_wdata,
    input  logic               ext_wen,
    input  logic [1:0]         ext_size,
    output logic [63:0]        ext_rdata,
    output logic               ext_ack,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam logic [3:0]         WAIT_LAST = 4'(WAIT_CYC);
    localparam logic [SRAM_AW-1:0] HW_ONE    = SRAM_AW'(1);

    state_e       state;
    logic [63:0]  wdata_q;
    logic         wen_q;
    logic [1:0]   size_q;
    logic         odd_q;
    logic [1:0]   beat;
    logic [2:0]   nbeats;
    logic [3:0]   wait_cnt;
    logic [SRAM_AW-1:0] start_hw;
    logic         is_byte;

    // Address bits above the SRAM are intentionally dropped (wrap).
    logic unused_addr;
    assign unused_addr = ^ext_addr[63:SRAM_AW+1];

    assign is_byte = (ext_size == SZ_BYTE);

    // Align the start halfword down to the access size.
    always_comb begin
        start_hw = ext_addr[SRAM_AW:1];
        unique case (size_e'(ext_size))
            SZ_WORD:  start_hw[0]   = 1'b0;
            SZ_DWORD: start_hw[1:0] = 2'b00;
            default:  ;
        endcase
    end

    // Byte writes replicate the byte on both lanes; the strobes pick one.
    function automatic logic [15:0] chunk_of(
        input logic [63:0] d,
        input logic [1:0]  size,
        input logic [1:0]  n
    );
        logic [15:0] c;
        c = d[15:0];
        if (size == SZ_BYTE) begin
            c = {d[7:0], d[7:0]};
        end else begin
            unique case (n)
                2'd0: c = d[15:0];
                2'd1: c = d[31:16];
                2'd2: c = d[47:32];
                2'd3: c = d[63:48];
                default: c = d[15:0];
            endcase
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ext_ack    <= 1'b0;
            ext_rdata  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            odd_q      <= 1'b0;
            beat       <= 2'd0;
            nbeats     <= 3'd1;
            wait_cnt   <= 4'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ext_req) begin
                        wdata_q    <= ext_wdata;
                        wen_q      <= ext_wen;
                        size_q     <= ext_size;
                        odd_q      <= ext_addr[0];
                        ext_rdata  <= '0;
                        beat       <= 2'd0;
                        nbeats     <= beats_of(ext_size);
                        sram_addr  <= start_hw;
                        sram_dq_o  <= chunk_of(ext_wdata, ext_size, 2'd0);
                        sram_dq_oe <= ext_wen;
                        sram_ce_n  <= 1'b0;
                        sram_lb_n  <= is_byte & ext_addr[0];
                        sram_ub_n  <= is_byte & ~ext_addr[0];
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    sram_we_n <= ~wen_q;
                    sram_oe_n <= wen_q;
                    wait_cnt  <= 4'd1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (wait_cnt == WAIT_LAST) begin
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (!wen_q) begin
                            if (size_q == SZ_BYTE) begin
                                ext_rdata <= {56'd0, odd_q ? sram_dq_i[15:8]
                                                           : sram_dq_i[7:0]};
                            end else begin
                                ext_rdata[{beat, 4'b0000} +: 16] <= sram_dq_i;
                            end
                        end
                        if ({1'b0, beat} + 3'd1 < nbeats) begin
                            beat      <= beat + 2'd1;
                            sram_addr <= sram_addr + HW_ONE;
                            sram_dq_o <= chunk_of(wdata_q, size_q, beat + 2'd1);
                            state     <= ST_SETUP;
                        end else begin
                            sram_ce_n  <= 1'b1;
                            sram_ub_n  <= 1'b1;
                            sram_lb_n  <= 1'b1;
                            sram_dq_oe <= 1'b0;
                            ext_ack    <= 1'b1;
                            state      <= ST_ACK;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_ACK: begin
                    ext_ack <= 1'b0;
                    state   <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Wait for the initiator to drop req so it is not re-served.
                    if (!ext_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp64_ext_sram_ctrl.sv
// Self-checking bench: two controllers (WAIT_CYC=2 and 1) share stimulus,
// each with its own 16-bit SRAM model; a byte-array reference predicts all.
module tb_mp64_ext_sram_ctrl;

    localparam int AW = 12;
    localparam int HW = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_req;
    logic [63:0] ext_addr;
    logic [63:0] ext_wdata;
    logic        ext_wen;
    logic [1:0]  ext_size;

    logic [63:0]   rdata [2];
    logic          ack   [2];
    logic [AW-1:0] saddr [2];
    logic [15:0]   sdo   [2];
    logic [15:0]   sdi   [2];
    logic          soe   [2];
    logic          ce    [2];
    logic          we    [2];
    logic          oe    [2];
    logic          ub    [2];
    logic          lb    [2];

    logic [15:0] mem [2][HW];
    logic [7:0]  ref_mem [2*HW];

    int n_checks = 0;
    int n_fail   = 0;

    bit          mon_on;
    int          t;
    bit          seen [2];
    int          ack_cyc [2];
    int          n_ack [2];
    bit          c_wen;
    bit          c_byte;
    bit          c_ub;
    bit          c_lb;
    int          c_beats;
    int          c_start;
    logic [63:0] c_wdata;
    logic [63:0] c_rexp;

    always #5 clk = ~clk;

    mp64_ext_sram_ctrl #(.SRAM_AW(AW), .WAIT_CYC(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_wen(ext_wen), .ext_size(ext_size),
        .ext_rdata(rdata[0]), .ext_ack(ack[0]),
        .sram_addr(saddr[0]), .sram_dq_o(sdo[0]), .sram_dq_i(sdi[0]),
        .sram_dq_oe(soe[0]), .sram_ce_n(ce[0]), .sram_we_n(we[0]),
        .sram_oe_n(oe[0]), .sram_ub_n(ub[0]), .sram_lb_n(lb[0])
    );

    mp64_ext_sram_ctrl #(.SRAM_AW(AW), .WAIT_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_wen(ext_wen), .ext_size(ext_size),
        .ext_rdata(rdata[1]), .ext_ack(ack[1]),
        .sram_addr(saddr[1]), .sram_dq_o(sdo[1]), .sram_dq_i(sdi[1]),
        .sram_dq_oe(soe[1]), .sram_ce_n(ce[1]), .sram_we_n(we[1]),
        .sram_oe_n(oe[1]), .sram_ub_n(ub[1]), .sram_lb_n(lb[1])
    );

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 40503 + 777);
    endfunction

    // Asynchronous SRAM: drives the bus only while selected for read.
    assign sdi[0] = (!ce[0] && !oe[0] && we[0]) ? mem[0][saddr[0]] : 16'h5A5A;
    assign sdi[1] = (!ce[1] && !oe[1] && we[1]) ? mem[1][saddr[1]] : 16'h5A5A;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < HW; i++)
                mem[d][i] = init_val(i);
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n && !ce[d] && !we[d]) begin
                    if (!lb[d]) mem[d][saddr[d]][7:0]  <= sdo[d][7:0];
                    if (!ub[d]) mem[d][saddr[d]][15:8] <= sdo[d][15:8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Expected pins derived from the timeline: each beat is one setup
    // cycle plus W strobe cycles, then a single ack cycle, then idle.
    task automatic compare_outputs();
        int w, l, n, p;
        logic [6:0] exp_s, act_s;
        logic [15:0] exp_d;
        for (int d = 0; d < 2; d++) begin
            w = (d == 0) ? 2 : 1;
            l = c_beats * (w + 1);
            act_s = {ce[d], we[d], oe[d], ub[d], lb[d], soe[d], ack[d]};
            if (t < l) begin
                n = t / (w + 1);
                p = t % (w + 1);
                exp_s = {1'b0, !(p > 0 && c_wen), !(p > 0 && !c_wen),
                         c_ub, c_lb, c_wen, 1'b0};
                chk($sformatf("addr%0d", d), 64'(saddr[d]),
                    64'((c_start + n) % HW));
                if (c_wen) begin
                    exp_d = c_byte ? {c_wdata[7:0], c_wdata[7:0]}
                                   : c_wdata[16*n +: 16];
                    chk($sformatf("dq_o%0d", d), 64'(sdo[d]), 64'(exp_d));
                end
            end else begin
                exp_s = {6'b111110, t == l};
                chk($sformatf("rdata%0d", d), rdata[d], c_rexp);
            end
            chk($sformatf("pins%0d", d), 64'(act_s), 64'(exp_s));
            if (ack[d]) begin
                n_ack[d]++;
                if (t == l) begin
                    seen[d]    = 1'b1;
                    ack_cyc[d] = t + 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_on) begin
            compare_outputs();
            t++;
        end
    endtask

    task automatic reset_check(input string name);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_pins%0d", name, d),
                64'({ce[d], we[d], oe[d], ub[d], lb[d], soe[d], ack[d]}),
                64'(7'b1111100));
            chk($sformatf("%s_addr%0d", name, d), 64'(saddr[d]), 64'd0);
            chk($sformatf("%s_dq%0d", name, d), 64'(sdo[d]), 64'd0);
            chk($sformatf("%s_rdata%0d", name, d), rdata[d], 64'd0);
        end
    endtask

    task automatic scramble();
        ext_addr  = {$urandom, $urandom};
        ext_wdata = {$urandom, $urandom};
        ext_wen   = 1'($urandom);
        ext_size  = 2'($urandom);
    endtask

    task automatic do_txn(input bit wen, input logic [1:0] size,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input int hold, input int abort_at);
        int nbytes, a, h;
        nbytes  = 1 << size;
        a       = int'(addr[AW:0]) & ~(nbytes - 1);
        c_beats = (nbytes + 1) / 2;
        c_start = a >> 1;
        c_wen   = wen;
        c_wdata = wdata;
        c_byte  = (nbytes == 1);
        c_lb    = c_byte && addr[0];
        c_ub    = c_byte && !addr[0];
        c_rexp  = '0;
        for (int i = 0; i < nbytes; i++) begin
            if (!wen) c_rexp[8*i +: 8] = ref_mem[a + i];
            else if (abort_at == 0) ref_mem[a + i] = wdata[8*i +: 8];
        end
        ext_req   = 1'b1;
        ext_wen   = wen;
        ext_size  = size;
        ext_addr  = addr;
        ext_wdata = wdata;
        t = 0;
        seen = '{1'b0, 1'b0};
        n_ack = '{0, 0};
        ack_cyc = '{0, 0};
        mon_on = 1'b1;
        tick();
        for (int k = 0; k < 80 && !(seen[0] && seen[1]); k++) begin
            if (abort_at != 0 && t == abort_at) break;
            scramble();
            tick();
        end
        if (abort_at != 0) begin
            mon_on = 1'b0;
            rst_n  = 1'b0;
            tick();
            reset_check("abort");
            tick();
            reset_check("abort_hold");
            chk("abort_no_ack", 64'(n_ack[0] + n_ack[1]), 64'd0);
            ext_req = 1'b0;
            rst_n   = 1'b1;
            tick();
            return;
        end
        chk("ack_seen", 64'({seen[1], seen[0]}), 64'd3);
        repeat (hold) begin
            scramble();
            tick();
        end
        ext_req = 1'b0;
        repeat (3) tick();
        mon_on = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ack_count%0d", d), 64'(n_ack[d]), 64'd1);
            for (int b = 0; b < c_beats; b++) begin
                h = c_start + b;
                chk($sformatf("mem%0d_%03h", d, h), 64'(mem[d][h]),
                    64'({ref_mem[2*h+1], ref_mem[2*h]}));
            end
        end
    endtask

    initial begin
        logic [15:0] iv;
        for (int i = 0; i < HW; i++) begin
            iv = init_val(i);
            ref_mem[2*i]   = iv[7:0];
            ref_mem[2*i+1] = iv[15:8];
        end
        mon_on    = 1'b0;
        t         = 0;
        rst_n     = 1'b0;
        ext_req   = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;
        ext_wen   = 1'b0;
        ext_size  = 2'd0;
        repeat (3) tick();
        reset_check("reset");
        rst_n = 1'b1;
        tick();

        do_txn(1'b1, 2'd3, 64'h100, 64'h1122_3344_5566_7788, 0, 0);
        chk("dw_ack_cyc0", 64'(ack_cyc[0]), 64'd13);
        chk("dw_ack_cyc1", 64'(ack_cyc[1]), 64'd9);
        chk("hw80", 64'(mem[0][12'h080]), 64'h7788);
        chk("hw81", 64'(mem[0][12'h081]), 64'h5566);
        chk("hw82", 64'(mem[0][12'h082]), 64'h3344);
        chk("hw83", 64'(mem[0][12'h083]), 64'h1122);

        do_txn(1'b0, 2'd3, 64'h100, 64'hFFFF_0000_FFFF_0000, 0, 0);
        chk("dw_read0", rdata[0], 64'h1122_3344_5566_7788);
        chk("dw_read1", rdata[1], 64'h1122_3344_5566_7788);
        chk("dw_rd_cyc0", 64'(ack_cyc[0]), 64'd13);

        iv = init_val(12'h101);
        do_txn(1'b1, 2'd0, 64'h203, 64'hFFFF_FFFF_FFFF_FFAB, 0, 0);
        chk("byte_ack_cyc0", 64'(ack_cyc[0]), 64'd4);
        chk("byte_hw101", 64'(mem[0][12'h101]), 64'({8'hAB, iv[7:0]}));
        chk("byte_wr_rdata", rdata[0], 64'd0);
        do_txn(1'b0, 2'd3, 64'h200, 64'd0, 0, 0);

        do_txn(1'b0, 2'd1, 64'h305, 64'd0, 0, 0);
        chk("half_upper", 64'(rdata[0][63:16]), 64'd0);
        chk("half_val", 64'(rdata[0][15:0]), 64'(mem[0][12'h182]));

        do_txn(1'b1, 2'd3, 64'h100, {$urandom, $urandom}, 3, 0);

        do_txn(1'b1, 2'd3, 64'h400, {$urandom, $urandom}, 0, 7);
        do_txn(1'b1, 2'd3, 64'h400, {$urandom, $urandom}, 0, 0);
        do_txn(1'b0, 2'd3, 64'h400, 64'd0, 0, 0);

        do_txn(1'b0, 2'd2, 64'h10A, 64'd0, 0, 0);
        chk("word_ack_cyc1", 64'(ack_cyc[1]), 64'd5);
        chk("word_ack_cyc0", 64'(ack_cyc[0]), 64'd7);

        do_txn(1'b1, 2'd0, 64'hFFFF_0000_0000_3FFE, 64'h5C, 0, 0);
        do_txn(1'b0, 2'd0, 64'h1FFE, 64'd0, 1, 0);
        chk("wrap_byte", rdata[0], 64'h5C);

        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom), 2'($urandom), {$urandom, $urandom},
                   {$urandom, $urandom}, int'($urandom_range(0, 3)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
